// File: rtl/misr_sig.sv
// misr_sig: per-frame CRC-16/CCITT signature capture for the red, green and
// blue pixel channels, with a latched, host-acknowledged result.
//
// Optional feature: define MISR_SIG_PIXCNT_EN to add the sig_pixcnt output.
// That output carries a saturating count of the enabled pixels, and the count
// is latched together with the signatures.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no capture armed; enable_crc and misr_done edges ignored
// RUN    | capture armed; enabled pixels fold into the running CRCs
// DONE   | signatures latched; waiting for sig_ack or a new init_crc

module misr_sig #(
  parameter logic [15:0] SEED = 16'hFFFF
) (
  input  logic        pixclk,
  input  logic        reset,
  input  logic        init_crc,
  input  logic        enable_crc,
  input  logic        misr_done,
  input  logic [7:0]  pix_red,
  input  logic [7:0]  pix_grn,
  input  logic [7:0]  pix_blu,
  input  logic        sig_ack,
  output logic [15:0] sig_red,
  output logic [15:0] sig_grn,
  output logic [15:0] sig_blu,
  output logic        sig_valid,
  output logic        sig_ovf,
`ifdef MISR_SIG_PIXCNT_EN
  output logic [23:0] sig_pixcnt,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_done_q;
  logic [15:0] r_crc_red;
  logic [15:0] r_crc_grn;
  logic [15:0] r_crc_blu;
  logic [15:0] r_sig_red;
  logic [15:0] r_sig_grn;
  logic [15:0] r_sig_blu;
  logic        r_sig_valid;
  logic        r_sig_ovf;

  logic        w_done_rise;
  logic        w_advance;
  logic        w_latch;
  logic [15:0] w_crc_red_nxt;
  logic [15:0] w_crc_grn_nxt;
  logic [15:0] w_crc_blu_nxt;

  // One byte of CRC-16/CCITT: poly 0x1021, MSB first, no reflection.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in,
                                             input logic [7:0]  data);
    logic [15:0] c;
    c = crc_in ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (c[15]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else       c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  assign w_done_rise = misr_done & ~r_done_q;
  assign w_advance   = (r_state == S_RUN) & enable_crc;
  // init_crc beats a coincident misr_done edge, so it also suppresses the latch.
  assign w_latch     = (r_state == S_RUN) & w_done_rise & ~init_crc;

  // The latched value must include the pixel that arrives on the latch cycle.
  // For that reason the latch copies the next-state CRCs.
  assign w_crc_red_nxt = w_advance ? crc16_byte(r_crc_red, pix_red) : r_crc_red;
  assign w_crc_grn_nxt = w_advance ? crc16_byte(r_crc_grn, pix_grn) : r_crc_grn;
  assign w_crc_blu_nxt = w_advance ? crc16_byte(r_crc_blu, pix_blu) : r_crc_blu;

  // State register.
  always_ff @(posedge pixclk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; init_crc re-arms from any state.
  always_comb begin
    w_state_nxt = r_state;
    if (init_crc) begin
      w_state_nxt = S_RUN;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_IDLE;
        S_RUN:   if (w_done_rise) w_state_nxt = S_DONE;
        S_DONE:  if (sig_ack) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Running CRCs, misr_done edge detect, signature latch and status flags.
  always_ff @(posedge pixclk) begin
    if (!reset) begin
      r_done_q    <= 1'b0;
      r_crc_red   <= 16'h0000;
      r_crc_grn   <= 16'h0000;
      r_crc_blu   <= 16'h0000;
      r_sig_red   <= 16'h0000;
      r_sig_grn   <= 16'h0000;
      r_sig_blu   <= 16'h0000;
      r_sig_valid <= 1'b0;
      r_sig_ovf   <= 1'b0;
    end else begin
      r_done_q <= misr_done;
      if (init_crc) begin
        r_crc_red <= SEED;
        r_crc_grn <= SEED;
        r_crc_blu <= SEED;
      end else begin
        r_crc_red <= w_crc_red_nxt;
        r_crc_grn <= w_crc_grn_nxt;
        r_crc_blu <= w_crc_blu_nxt;
      end
      if (w_latch) begin
        r_sig_red <= w_crc_red_nxt;
        r_sig_grn <= w_crc_grn_nxt;
        r_sig_blu <= w_crc_blu_nxt;
      end
      // A latch wins over a same-cycle ack, so the new result stays valid.
      if (w_latch)      r_sig_valid <= 1'b1;
      else if (sig_ack) r_sig_valid <= 1'b0;
      if (w_latch && r_sig_valid && !sig_ack) r_sig_ovf <= 1'b1;
      else if (sig_ack)                       r_sig_ovf <= 1'b0;
    end
  end

`ifdef MISR_SIG_PIXCNT_EN
  logic [23:0] r_pixcnt;
  logic [23:0] r_sig_pixcnt;
  logic [23:0] w_pixcnt_nxt;

  assign w_pixcnt_nxt = (w_advance && (r_pixcnt != 24'hFFFFFF)) ? r_pixcnt + 24'd1
                                                                : r_pixcnt;

  // Saturating enabled-pixel counter, latched alongside the signatures.
  always_ff @(posedge pixclk) begin
    if (!reset) begin
      r_pixcnt     <= 24'd0;
      r_sig_pixcnt <= 24'd0;
    end else begin
      if (init_crc) r_pixcnt <= 24'd0;
      else          r_pixcnt <= w_pixcnt_nxt;
      if (w_latch)  r_sig_pixcnt <= w_pixcnt_nxt;
    end
  end

  assign sig_pixcnt = r_sig_pixcnt;
`endif

  assign sig_red   = r_sig_red;
  assign sig_grn   = r_sig_grn;
  assign sig_blu   = r_sig_blu;
  assign sig_valid = r_sig_valid;
  assign sig_ovf   = r_sig_ovf;
  assign busy      = (r_state == S_RUN);

endmodule

// File: tb/tb_misr_sig.sv
// tb_misr_sig: randomized and directed stimulus for misr_sig.
// The reference model keeps the list of enabled bytes captured since the last
// init_crc. It recomputes each signature from that list when a latch happens.

module tb_misr_sig;

  typedef logic [7:0] bq_t[$];

  logic        pixclk = 1'b0;
  logic        reset = 1'b0;
  logic        init_crc = 1'b0;
  logic        enable_crc = 1'b0;
  logic        misr_done = 1'b0;
  logic        sig_ack = 1'b0;
  logic [7:0]  pix_red = 8'h00;
  logic [7:0]  pix_grn = 8'h00;
  logic [7:0]  pix_blu = 8'h00;
  logic [15:0] sig_red, sig_grn, sig_blu;
  logic        sig_valid, sig_ovf, busy;
`ifdef MISR_SIG_PIXCNT_EN
  logic [23:0] sig_pixcnt;
`endif

  misr_sig #(.SEED(16'hFFFF)) dut (
    .pixclk     (pixclk),
    .reset      (reset),
    .init_crc   (init_crc),
    .enable_crc (enable_crc),
    .misr_done  (misr_done),
    .pix_red    (pix_red),
    .pix_grn    (pix_grn),
    .pix_blu    (pix_blu),
    .sig_ack    (sig_ack),
    .sig_red    (sig_red),
    .sig_grn    (sig_grn),
    .sig_blu    (sig_blu),
    .sig_valid  (sig_valid),
    .sig_ovf    (sig_ovf),
`ifdef MISR_SIG_PIXCNT_EN
    .sig_pixcnt (sig_pixcnt),
`endif
    .busy       (busy)
  );

  always #5 pixclk = ~pixclk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  int          m_state = 0;        // 0 idle, 1 capturing, 2 result held
  logic [15:0] m_base = 16'h0000;
  bq_t         q_r, q_g, q_b;
  logic [15:0] m_sig_r = 16'h0, m_sig_g = 16'h0, m_sig_b = 16'h0;
  logic        m_valid = 1'b0, m_ovf = 1'b0, m_done_q = 1'b0;
  int          m_sig_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bit-serial CRC-16/CCITT over a byte list.
  function automatic logic [15:0] ref_crc(input logic [15:0] base, input bq_t q);
    logic [15:0] c;
    logic        fb;
    c = base;
    foreach (q[k]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[15] ^ q[k][b];
        c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
    return c;
  endfunction

  task automatic model_step();
    logic rise, latch;
    if (!reset) begin
      m_state = 0; m_base = 16'h0000;
      q_r.delete(); q_g.delete(); q_b.delete();
      m_sig_r = 16'h0; m_sig_g = 16'h0; m_sig_b = 16'h0;
      m_valid = 1'b0; m_ovf = 1'b0; m_done_q = 1'b0; m_sig_cnt = 0;
    end else begin
      rise  = misr_done && !m_done_q;
      latch = (m_state == 1) && rise && !init_crc;
      if (init_crc) begin
        m_base = 16'hFFFF;
        q_r.delete(); q_g.delete(); q_b.delete();
      end else if (m_state == 1 && enable_crc) begin
        q_r.push_back(pix_red); q_g.push_back(pix_grn); q_b.push_back(pix_blu);
      end
      if (latch) begin
        m_sig_r = ref_crc(m_base, q_r);
        m_sig_g = ref_crc(m_base, q_g);
        m_sig_b = ref_crc(m_base, q_b);
        m_sig_cnt = (q_r.size() > 24'hFFFFFF) ? 24'hFFFFFF : q_r.size();
        if (m_valid && !sig_ack) m_ovf = 1'b1;
        else if (sig_ack)        m_ovf = 1'b0;
        m_valid = 1'b1;
      end else if (sig_ack) begin
        m_valid = 1'b0;
        m_ovf   = 1'b0;
      end
      if (init_crc)                      m_state = 1;
      else if (m_state == 1 && rise)     m_state = 2;
      else if (m_state == 2 && sig_ack)  m_state = 0;
      m_done_q = misr_done;
    end
  endtask

  task automatic check_all();
    chk("sig_red",   32'(sig_red),   32'(m_sig_r));
    chk("sig_grn",   32'(sig_grn),   32'(m_sig_g));
    chk("sig_blu",   32'(sig_blu),   32'(m_sig_b));
    chk("sig_valid", 32'(sig_valid), 32'(m_valid));
    chk("sig_ovf",   32'(sig_ovf),   32'(m_ovf));
    chk("busy",      32'(busy),      32'(m_state == 1));
`ifdef MISR_SIG_PIXCNT_EN
    chk("sig_pixcnt", 32'(sig_pixcnt), 32'(m_sig_cnt));
`endif
  endtask

  task automatic tick();
    @(posedge pixclk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle_in();
    init_crc = 1'b0; enable_crc = 1'b0; misr_done = 1'b0; sig_ack = 1'b0;
  endtask

  task automatic rand_pix();
    pix_red = 8'($urandom); pix_grn = 8'($urandom); pix_blu = 8'($urandom);
  endtask

  task automatic ack_cycle();
    idle_in(); sig_ack = 1'b1; tick(); sig_ack = 1'b0;
  endtask

  initial begin
    string s;
    int    idx;
    s = "123456789";

    // Reset
    reset = 1'b0; idle_in();
    repeat (3) tick();
    chk("rst_sig_red", 32'(sig_red), 32'h0);
    chk("rst_valid",   32'(sig_valid), 32'h0);
    chk("rst_busy",    32'(busy), 32'h0);
    reset = 1'b1;
    tick();

    // Check string, with the done edge on the last pixel
    init_crc = 1'b1; tick(); init_crc = 1'b0;
    chk("init_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 9; i++) begin
      enable_crc = 1'b1; rand_pix(); pix_red = s[i]; misr_done = (i == 8);
      tick();
      if (i < 8) chk("no_early_valid", 32'(sig_valid), 32'h0);
    end
    chk("crc_123456789", 32'(sig_red), 32'h29B1);
    chk("valid_after_9", 32'(sig_valid), 32'h1);
`ifdef MISR_SIG_PIXCNT_EN
    chk("pixcnt_9", 32'(sig_pixcnt), 32'd9);
`endif
    ack_cycle();
    chk("ack_idle_busy", 32'(busy), 32'h0);

    // Empty frame gives the seed
    init_crc = 1'b1; tick(); idle_in();
    misr_done = 1'b1; tick();
    chk("empty_red", 32'(sig_red), 32'hFFFF);
    chk("empty_grn", 32'(sig_grn), 32'hFFFF);
    chk("empty_blu", 32'(sig_blu), 32'hFFFF);
    chk("empty_valid", 32'(sig_valid), 32'h1);
    ack_cycle();

    // Check string with disabled gaps of random data
    init_crc = 1'b1; tick(); idle_in();
    idx = 0;
    while (idx < 9) begin
      rand_pix();
      if ($urandom_range(0, 1) == 0) begin
        enable_crc = 1'b0; misr_done = 1'b0;
      end else begin
        enable_crc = 1'b1; pix_red = s[idx]; misr_done = (idx == 8); idx++;
      end
      tick();
    end
    chk("gaps_crc", 32'(sig_red), 32'h29B1);
    ack_cycle();

    // Overflow: second latch with no ack in between
    init_crc = 1'b1; tick(); idle_in();
    for (int i = 0; i < 3; i++) begin
      enable_crc = 1'b1; rand_pix(); misr_done = (i == 2); tick();
    end
    idle_in(); tick();
    init_crc = 1'b1; tick(); idle_in();
    chk("init_keeps_valid", 32'(sig_valid), 32'h1);
    for (int i = 0; i < 4; i++) begin
      enable_crc = 1'b1; rand_pix(); misr_done = (i == 3); tick();
    end
    chk("ovf_set", 32'(sig_ovf), 32'h1);
    chk("ovf_valid", 32'(sig_valid), 32'h1);
    ack_cycle();
    chk("ovf_ack_valid", 32'(sig_valid), 32'h0);
    chk("ovf_ack_ovf", 32'(sig_ovf), 32'h0);
    chk("ovf_ack_busy", 32'(busy), 32'h0);

    // init_crc and misr_done edge together: no latch, stays in RUN
    init_crc = 1'b1; misr_done = 1'b1; tick();
    chk("coinc_busy", 32'(busy), 32'h1);
    chk("coinc_nolatch", 32'(sig_valid), 32'h0);
    idle_in(); tick();
    misr_done = 1'b1; tick();
    chk("coinc_seed", 32'(sig_red), 32'hFFFF);
    ack_cycle();

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      reset      = ($urandom_range(0, 199) != 0);
      init_crc   = ($urandom_range(0, 99) < 4);
      enable_crc = ($urandom_range(0, 99) < 70);
      sig_ack    = ($urandom_range(0, 99) < 6);
      if ($urandom_range(0, 99) < 15) misr_done = ~misr_done;
      rand_pix();
      tick();
    end
    reset = 1'b1; idle_in(); tick();

    // Reset mid-capture overrides init_crc and a pending latch
    init_crc = 1'b1; tick(); idle_in();
    for (int i = 0; i < 3; i++) begin
      enable_crc = 1'b1; rand_pix(); misr_done = (i == 2); tick();
    end
    idle_in(); init_crc = 1'b1; tick(); idle_in();
    enable_crc = 1'b1; rand_pix(); tick();
    reset = 1'b0; init_crc = 1'b1; misr_done = 1'b1; tick();
    chk("midrst_red", 32'(sig_red), 32'h0);
    chk("midrst_valid", 32'(sig_valid), 32'h0);
    chk("midrst_ovf", 32'(sig_ovf), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    reset = 1'b1; idle_in(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
